// File: rtl/softmax_pkg.sv
// Shared softmax vector types, used by softmax, its output serializer and their benches.
package softmax_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned WIDTH = 8;

  typedef logic [WIDTH-1:0] lane_t;
  typedef lane_t [LANES-1:0] vec_t;

endpackage

// File: rtl/vec_fifo.sv
// Small vector FIFO: DEPTH whole vectors, wrapping pointers, occupancy count.
// The caller only pops when not empty and only pushes when not full or popping.
module vec_fifo
  import softmax_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type vec_t = softmax_pkg::vec_t
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  vec_t                         wr_data,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output vec_t                         head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  vec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy bookkeeping; push+pop leaves the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Vector storage; contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/softmax_out_serializer.sv
// Captures softmax result vectors into a small FIFO and streams them out as
// lane-ordered bytes with an end-of-vector marker. Softmax cannot be stalled,
// so vectors arriving to a full buffer are dropped and counted.
module softmax_out_serializer #(
  parameter int unsigned LANES = softmax_pkg::LANES,
  parameter int unsigned WIDTH = softmax_pkg::WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             input_valid,
  input  logic [WIDTH-1:0] input_bits_data_in_0,
  input  logic [WIDTH-1:0] input_bits_data_in_1,
  input  logic [WIDTH-1:0] input_bits_data_in_2,
  input  logic [WIDTH-1:0] input_bits_data_in_3,
  input  logic [WIDTH-1:0] input_bits_data_in_4,
  input  logic [WIDTH-1:0] input_bits_data_in_5,
  input  logic [WIDTH-1:0] input_bits_data_in_6,
  input  logic [WIDTH-1:0] input_bits_data_in_7,
  input  logic [WIDTH-1:0] input_bits_data_in_8,
  input  logic [WIDTH-1:0] input_bits_data_in_9,
  input  logic [WIDTH-1:0] input_bits_data_in_10,
  input  logic [WIDTH-1:0] input_bits_data_in_11,
  input  logic [WIDTH-1:0] input_bits_data_in_12,
  input  logic [WIDTH-1:0] input_bits_data_in_13,
  input  logic [WIDTH-1:0] input_bits_data_in_14,
  input  logic [WIDTH-1:0] input_bits_data_in_15,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [WIDTH-1:0] output_bits_data,
  output logic             output_bits_last,
  output logic             overflow,
  output logic [7:0]       drop_count
);

  import softmax_pkg::vec_t;

  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [7:0]        DROP_MAX  = 8'hFF;

  vec_t              in_vec;
  vec_t              head;
  logic [LANE_W-1:0] lane;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              xfer;
  logic              pop;
  logic              push;
  logic              drop;
  logic              unused_fifo_count;

  // Gather the individual softmax lanes into one vector.
  always_comb begin
    in_vec     = '0;
    in_vec[0]  = input_bits_data_in_0;
    in_vec[1]  = input_bits_data_in_1;
    in_vec[2]  = input_bits_data_in_2;
    in_vec[3]  = input_bits_data_in_3;
    in_vec[4]  = input_bits_data_in_4;
    in_vec[5]  = input_bits_data_in_5;
    in_vec[6]  = input_bits_data_in_6;
    in_vec[7]  = input_bits_data_in_7;
    in_vec[8]  = input_bits_data_in_8;
    in_vec[9]  = input_bits_data_in_9;
    in_vec[10] = input_bits_data_in_10;
    in_vec[11] = input_bits_data_in_11;
    in_vec[12] = input_bits_data_in_12;
    in_vec[13] = input_bits_data_in_13;
    in_vec[14] = input_bits_data_in_14;
    in_vec[15] = input_bits_data_in_15;
  end

  // Handshake decode: a pop frees a slot in the same cycle, so a push that
  // lands on the final-lane transfer of a full FIFO is accepted, not dropped.
  always_comb begin
    xfer = output_valid & output_ready;
    pop  = xfer & (lane == LAST_LANE);
    push = input_valid & (~fifo_full | pop);
    drop = input_valid & fifo_full & ~pop;
  end

  vec_fifo #(
    .DEPTH (DEPTH),
    .vec_t (vec_t)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (in_vec),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (head)
  );

  // Occupancy is only needed as empty/full here.
  assign unused_fifo_count = ^fifo_count;

  // Lane counter walks the head vector; it wraps exactly when the head is popped.
  always_ff @(posedge clock) begin
    if (reset) begin
      lane <= '0;
    end else if (xfer) begin
      lane <= (lane == LAST_LANE) ? '0 : lane + LANE_W'(1);
    end
  end

  // Drop accounting: sticky flag plus a saturating 8-bit count.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != DROP_MAX) drop_count <= drop_count + 8'(1);
    end
  end

  // Output side: all terms come from registers; data is the head lane mux.
  assign output_valid     = ~fifo_empty;
  assign output_bits_data = WIDTH'(head[lane]);
  assign output_bits_last = output_valid & (lane == LAST_LANE);

endmodule
